line_fetch_arbiter: RTL and testbench
=====================================

LINE_FETCH_ARBITER -- requirements
Module: line_fetch_arbiter

Interface
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning:
- LINE_WORDS, 400: words fetched per visible line.
- ADDR_WIDTH, 17: memory word-address width.
- Y_WIDTH, 9: y_index width.
- BURST_LEN, 8: reads issued before a host slot is offered (interleave build only).
REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning:
- clk, in, 1: the single clock; the block has one clock.
- reset, in, 1: asynchronous, active-high reset.
- line_start, in, 1: one-cycle pulse at each line start from video timing.
- y_index, in, Y_WIDTH: next visible line number.
- y_index_valid, in, 1: y_index is a visible line.
- mem_addr, out, ADDR_WIDTH: memory address.
- mem_rd, out, 1: read request.
- mem_wr, out, 1: write request.
- mem_wdata, out, 24: write data (rgb_t).
- mem_ready, in, 1: memory accepts mem_rd/mem_wr this cycle.
- mem_rdata, in, 24: read data.
- mem_rvalid, in, 1: read data valid; reads return in order.
- lb_wr, out, 1: line-buffer write strobe.
- lb_addr, out, $clog2(LINE_WORDS): line-buffer word index.
- lb_data, out, 24: line-buffer data.
- lb_bank, out, 1: bank being filled; the display side reads ~lb_bank.
- host_req, in, 1: host write pending; held until granted.
- host_addr, in, ADDR_WIDTH: host write address.
- host_wdata, in, 24: host write data.
- host_gnt, out, 1: one-cycle pulse; the host write was accepted by memory.
- underrun, out, 1: one-cycle pulse; a fetch was still incomplete at line_start.
- underrun_count, out, 8: saturating count of underrun pulses.

Function
REQ-003 On line_start with y_index_valid=1, the block SHALL toggle lb_bank, latch base = y_index*LINE_WORDS truncated to ADDR_WIDTH, and set fetch_pending.
REQ-004 On line_start with y_index_valid=0, the block SHALL only toggle lb_bank.
REQ-005 The FSM SHALL have the states IDLE, FETCH, DRAIN and HOST.
REQ-006 IDLE transitions:
- fetch_pending goes to FETCH; fetch_pending has priority over host_req.
- host_req goes to HOST otherwise.
REQ-007 FETCH SHALL drive mem_rd=1 with mem_addr=base+issue_cnt.
REQ-008 In FETCH, issue_cnt SHALL increment only on mem_rd&&mem_ready; after issue LINE_WORDS-1 is accepted the FSM SHALL go to DRAIN.
REQ-009 Return handling in every state: on each mem_rvalid, lb_wr=1, lb_data=mem_rdata and lb_addr=ret_cnt, all combinational, and ret_cnt SHALL increment.
REQ-010 DRAIN SHALL go to IDLE on the cycle ret_cnt reaches LINE_WORDS; on that edge fetch_pending, issue_cnt and ret_cnt SHALL clear.
REQ-011 HOST SHALL drive mem_wr=1 with mem_addr=host_addr and mem_wdata=host_wdata.
REQ-012 In HOST, on mem_ready the block SHALL pulse host_gnt and return to IDLE, giving one write per grant.
REQ-013 mem_rd and mem_wr SHALL never both be 1; both SHALL be 0 in IDLE and DRAIN.
REQ-014 A line_start arriving while in FETCH or DRAIN SHALL:
- pulse underrun for 1 cycle;
- increment underrun_count, saturating at 255;
- let the current fetch complete into the now-displayed bank;
- queue the new fetch (fetch_pending, new base) to start from IDLE.
REQ-015 At most one fetch SHALL be queued; a further line_start overwrites the queued base and raises another underrun.
REQ-016 The block SHALL hold no combinational path from mem_ready to mem_rd or mem_wr.

Reset
REQ-017 While reset=1, the block SHALL hold:
- state=IDLE, fetch_pending=0 and all counters 0;
- lb_bank=0, underrun_count=0;
- mem_rd, mem_wr, lb_wr, host_gnt and underrun at 0;
- mem_addr, mem_wdata, lb_addr and lb_data at 0.
REQ-018 A reset mid-fetch SHALL abandon in-flight reads; mem_rvalid arriving after reset release SHALL be ignored until the next FETCH.

Configuration
REQ-019 With LINE_FETCH_HOST_INTERLEAVE_EN defined, FETCH SHALL go to HOST after every BURST_LEN accepted reads when host_req=1, then return to FETCH after the grant.
REQ-020 Without LINE_FETCH_HOST_INTERLEAVE_EN, HOST SHALL be entered only from IDLE.

Structure
REQ-021 pocket_pkg SHALL hold rgb_t and the fetch_state_t enum.
REQ-022 underrun_count SHALL be a sub-module sat_counter (WIDTH=8).

Verification
REQ-023 The bench SHALL cover these scenarios (LINE_WORDS=4, mem_ready=1, rvalid latency 2):
- line_start, y_index=3 -> reads at addresses 12..15 on 4 consecutive cycles; lb_addr 0..3; DRAIN to IDLE 2 cycles later.
- host_req held in IDLE -> one mem_wr to host_addr and host_gnt one cycle later.
- line_start and host_req on the same cycle -> fetch first, then host write.
- second line_start during DRAIN -> underrun pulse, underrun_count=1, queued fetch runs after DRAIN.
- interleave build with BURST_LEN=2 and host_req held -> order rd, rd, wr, rd, rd.
- reset asserted mid-FETCH -> all outputs 0 immediately; no lb_wr after release.

Source files
------------

// File: rtl/pocket_pkg.sv
// Shared types for the line fetch arbiter: pixel word and fetch FSM states.
package pocket_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StDrain,
    StHost
  } fetch_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; holds at all-ones once reached.
module sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;

  // Count increments, stopping at the maximum value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (inc && (count_q != '1)) begin
      count_q <= count_q + WIDTH'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/line_fetch_arbiter.sv
// Line fetch arbiter: fetches one video line per line_start from memory into a
// double-banked line buffer and slots host writes in between fetches.
// Build option: define LINE_FETCH_HOST_INTERLEAVE_EN to offer a host write slot
// after every BURST_LEN accepted reads inside a fetch.
module line_fetch_arbiter
  import pocket_pkg::*;
#(
  parameter int unsigned LINE_WORDS = 400,
  parameter int unsigned ADDR_WIDTH = 17,
  parameter int unsigned Y_WIDTH    = 9,
  parameter int unsigned BURST_LEN  = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          line_start,
  input  logic [Y_WIDTH-1:0]            y_index,
  input  logic                          y_index_valid,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic                          mem_rd,
  output logic                          mem_wr,
  output rgb_t                          mem_wdata,
  input  logic                          mem_ready,
  input  rgb_t                          mem_rdata,
  input  logic                          mem_rvalid,
  output logic                          lb_wr,
  output logic [$clog2(LINE_WORDS)-1:0] lb_addr,
  output rgb_t                          lb_data,
  output logic                          lb_bank,
  input  logic                          host_req,
  input  logic [ADDR_WIDTH-1:0]         host_addr,
  input  rgb_t                          host_wdata,
  output logic                          host_gnt,
  output logic                          underrun,
  output logic [7:0]                    underrun_count
);

  localparam int unsigned CntW    = $clog2(LINE_WORDS + 1);
  localparam int unsigned LbAddrW = $clog2(LINE_WORDS);
  localparam int unsigned BurstW  = $clog2(BURST_LEN + 1);
  localparam logic [CntW-1:0]   LastIdx   = CntW'(LINE_WORDS - 1);
  localparam logic [BurstW-1:0] BurstLast = BurstW'(BURST_LEN - 1);

`ifdef LINE_FETCH_HOST_INTERLEAVE_EN
  localparam bit InterleaveEn = 1'b1;
`else
  localparam bit InterleaveEn = 1'b0;
`endif

  fetch_state_t          state_q, state_d;
  logic                  fetch_pending_q, fetch_pending_d;
  logic [ADDR_WIDTH-1:0] pend_base_q, pend_base_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [CntW-1:0]       issue_cnt_q, issue_cnt_d;
  logic [CntW-1:0]       ret_cnt_q, ret_cnt_d;
  logic [BurstW-1:0]     burst_cnt_q, burst_cnt_d;
  logic                  lb_bank_q;
  logic                  underrun_q, underrun_d;

  logic                  ls_valid;
  logic                  fetch_busy;
  logic                  ret_fire;
  logic [ADDR_WIDTH-1:0] line_base;

  assign ls_valid   = line_start && y_index_valid;
  assign line_base  = ADDR_WIDTH'(32'(y_index) * LINE_WORDS);
  // A fetch is outstanding in FETCH/DRAIN, or in HOST when it interrupted a fetch.
  assign fetch_busy = (state_q == StFetch) || (state_q == StDrain) ||
                      ((state_q == StHost) && (issue_cnt_q != '0));
  // Returns only count while reads are outstanding, so stale data after reset is dropped.
  assign ret_fire   = mem_rvalid && (ret_cnt_q < issue_cnt_q);
  assign underrun_d = line_start && fetch_busy;

  // Memory and line-buffer outputs; mem_rd/mem_wr depend on state only.
  always_comb begin
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    host_gnt  = 1'b0;
    case (state_q)
      StFetch: begin
        mem_rd   = 1'b1;
        mem_addr = base_q + ADDR_WIDTH'(issue_cnt_q);
      end
      StHost: begin
        mem_wr    = 1'b1;
        mem_addr  = host_addr;
        mem_wdata = host_wdata;
        host_gnt  = mem_ready;
      end
      default: ;
    endcase
    lb_wr   = ret_fire;
    lb_addr = ret_fire ? ret_cnt_q[LbAddrW-1:0] : '0;
    lb_data = ret_fire ? mem_rdata : '0;
  end

  // Next-state logic for the fetch FSM, counters and queued fetch.
  always_comb begin
    state_d         = state_q;
    fetch_pending_d = fetch_pending_q;
    pend_base_d     = pend_base_q;
    base_d          = base_q;
    issue_cnt_d     = issue_cnt_q;
    ret_cnt_d       = ret_cnt_q;
    burst_cnt_d     = burst_cnt_q;

    if (ret_fire) begin
      ret_cnt_d = ret_cnt_q + CntW'(1);
    end

    case (state_q)
      StIdle: begin
        // A line start this cycle outranks the host; wait for its base to latch.
        if (ls_valid) begin
          state_d = StIdle;
        end else if (fetch_pending_q) begin
          state_d         = StFetch;
          base_d          = pend_base_q;
          fetch_pending_d = 1'b0;
          issue_cnt_d     = '0;
          ret_cnt_d       = '0;
          burst_cnt_d     = '0;
        end else if (host_req) begin
          state_d = StHost;
        end
      end
      StFetch: begin
        if (mem_ready) begin
          issue_cnt_d = issue_cnt_q + CntW'(1);
          burst_cnt_d = (burst_cnt_q == BurstLast) ? '0 : burst_cnt_q + BurstW'(1);
          if (issue_cnt_q == LastIdx) begin
            state_d = StDrain;
          end else if (InterleaveEn && host_req && (burst_cnt_q == BurstLast)) begin
            state_d = StHost;
          end
        end
      end
      StDrain: begin
        if (ret_fire && (ret_cnt_q == LastIdx)) begin
          state_d     = StIdle;
          issue_cnt_d = '0;
          ret_cnt_d   = '0;
        end
      end
      StHost: begin
        if (mem_ready) begin
          state_d = (issue_cnt_q != '0) ? StFetch : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Only one fetch can be queued; a later line start replaces its base.
    if (ls_valid) begin
      fetch_pending_d = 1'b1;
      pend_base_d     = line_base;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= StIdle;
      fetch_pending_q <= 1'b0;
      pend_base_q     <= '0;
      base_q          <= '0;
      issue_cnt_q     <= '0;
      ret_cnt_q       <= '0;
      burst_cnt_q     <= '0;
      lb_bank_q       <= 1'b0;
      underrun_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      fetch_pending_q <= fetch_pending_d;
      pend_base_q     <= pend_base_d;
      base_q          <= base_d;
      issue_cnt_q     <= issue_cnt_d;
      ret_cnt_q       <= ret_cnt_d;
      burst_cnt_q     <= burst_cnt_d;
      lb_bank_q       <= lb_bank_q ^ line_start;
      underrun_q      <= underrun_d;
    end
  end

  assign lb_bank  = lb_bank_q;
  assign underrun = underrun_q;

  sat_counter #(
    .WIDTH(8)
  ) u_underrun_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (underrun_d),
    .count(underrun_count)
  );

endmodule

// File: tb/tb_line_fetch_arbiter.sv
// Directed bench for line_fetch_arbiter (LINE_WORDS=4, mem_ready=1, read latency 2).
module tb_line_fetch_arbiter;

  logic        clk;
  logic        reset;
  logic        line_start;
  logic [8:0]  y_index;
  logic        y_index_valid;
  logic [16:0] mem_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic [23:0] mem_wdata;
  logic        mem_ready;
  logic [23:0] mem_rdata;
  logic        mem_rvalid;
  logic        lb_wr;
  logic [1:0]  lb_addr;
  logic [23:0] lb_data;
  logic        lb_bank;
  logic        host_req;
  logic [16:0] host_addr;
  logic [23:0] host_wdata;
  logic        host_gnt;
  logic        underrun;
  logic [7:0]  underrun_count;

  int checks   = 0;
  int failures = 0;
  logic exp_bank;
  int s3_rd [8];
  int s3_wr [8];
  int s3_lb [8];
  int gnt_k;

  line_fetch_arbiter #(
    .LINE_WORDS(4),
    .ADDR_WIDTH(17),
    .Y_WIDTH   (9),
    .BURST_LEN (2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .line_start    (line_start),
    .y_index       (y_index),
    .y_index_valid (y_index_valid),
    .mem_addr      (mem_addr),
    .mem_rd        (mem_rd),
    .mem_wr        (mem_wr),
    .mem_wdata     (mem_wdata),
    .mem_ready     (mem_ready),
    .mem_rdata     (mem_rdata),
    .mem_rvalid    (mem_rvalid),
    .lb_wr         (lb_wr),
    .lb_addr       (lb_addr),
    .lb_data       (lb_data),
    .lb_bank       (lb_bank),
    .host_req      (host_req),
    .host_addr     (host_addr),
    .host_wdata    (host_wdata),
    .host_gnt      (host_gnt),
    .underrun      (underrun),
    .underrun_count(underrun_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [23:0] fdat(input logic [16:0] a);
    return 24'h5A0000 ^ {7'd0, a};
  endfunction

  // Memory model: in-order read data two cycles after an accepted read.
  logic        p1_v = 1'b0;
  logic        p2_v = 1'b0;
  logic [23:0] p1_d = '0;
  logic [23:0] p2_d = '0;
  always @(posedge clk) begin
    p1_v <= mem_rd && mem_ready;
    p1_d <= fdat(mem_addr);
    p2_v <= p1_v;
    p2_d <= p1_d;
  end
  assign mem_rvalid = p2_v;
  assign mem_rdata  = p2_d;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle of expected memory/line-buffer outputs.
  task automatic cyc(input string tag, input bit e_rd, input int e_addr, input bit e_wr,
                     input bit e_lbw, input int e_idx, input int e_daddr);
    chk({tag, "_rd"}, 32'(mem_rd), 32'(e_rd));
    chk({tag, "_wr"}, 32'(mem_wr), 32'(e_wr));
    chk({tag, "_gnt"}, 32'(host_gnt), 32'(e_wr));
    chk({tag, "_addr"}, 32'(mem_addr), e_addr);
    chk({tag, "_wdata"}, 32'(mem_wdata), e_wr ? 32'(host_wdata) : 32'd0);
    chk({tag, "_lbwr"}, 32'(lb_wr), 32'(e_lbw));
    chk({tag, "_lbaddr"}, 32'(lb_addr), e_lbw ? e_idx : 0);
    chk({tag, "_lbdata"}, 32'(lb_data), e_lbw ? 32'(fdat(17'(e_daddr))) : 32'd0);
  endtask

  initial begin
`ifdef LINE_FETCH_HOST_INTERLEAVE_EN
    s3_rd = '{20, 21, -1, 22, 23, -1, -1, -1};
    s3_wr = '{0, 0, 1, 0, 0, 0, 0, 0};
    s3_lb = '{-1, -1, 0, 1, -1, 2, 3, -1};
    gnt_k = 2;
`else
    s3_rd = '{20, 21, 22, 23, -1, -1, -1, -1};
    s3_wr = '{0, 0, 0, 0, 0, 0, 0, 1};
    s3_lb = '{-1, -1, 0, 1, 2, 3, -1, -1};
    gnt_k = 7;
`endif
    reset = 1'b1; line_start = 1'b0; y_index = '0; y_index_valid = 1'b0;
    mem_ready = 1'b1; host_req = 1'b0; host_addr = '0; host_wdata = '0;
    exp_bank = 1'b0;

    // Reset state
    step(); step();
    #1;
    cyc("rst", 0, 0, 0, 0, 0, 0);
    chk("rst_bank", 32'(lb_bank), 0);
    chk("rst_underrun", 32'(underrun), 0);
    chk("rst_ucount", 32'(underrun_count), 0);
    reset = 1'b0;
    step();

    // Line fetch of y=3: reads 12..15, returns 0..3, then idle
    line_start = 1'b1; y_index = 9'd3; y_index_valid = 1'b1;
    step();
    line_start = 1'b0; y_index_valid = 1'b0; exp_bank = ~exp_bank;
    #1;
    chk("s1_bank", 32'(lb_bank), 32'(exp_bank));
    chk("s1_idle_rd", 32'(mem_rd), 0);
    step();
    for (int k = 0; k < 6; k++) begin
      #1;
      cyc($sformatf("s1_c%0d", k), k < 4, (k < 4) ? 12 + k : 0, 0, (k >= 2), k - 2, 10 + k);
      step();
    end
    // Idle two cycles after the last read: a host request here is served next cycle
    #1;
    cyc("s1_idle", 0, 0, 0, 0, 0, 0);
    host_req = 1'b1; host_addr = 17'h1ABCD; host_wdata = 24'h123456;
    step();
    #1;
    cyc("s2_wr", 0, 32'h1ABCD, 1, 0, 0, 0);
    host_req = 1'b0;
    step();
    #1;
    cyc("s2_after", 0, 0, 0, 0, 0, 0);

    // Line start and host request together: fetch first, host after
    line_start = 1'b1; y_index = 9'd5; y_index_valid = 1'b1;
    host_req = 1'b1; host_addr = 17'h00077; host_wdata = 24'hABCDEF;
    step();
    line_start = 1'b0; y_index_valid = 1'b0; exp_bank = ~exp_bank;
    #1;
    cyc("s3_idle", 0, 0, 0, 0, 0, 0);
    chk("s3_bank", 32'(lb_bank), 32'(exp_bank));
    step();
    for (int k = 0; k < 8; k++) begin
      #1;
      cyc($sformatf("s3_c%0d", k), s3_rd[k] >= 0,
          (s3_rd[k] >= 0) ? s3_rd[k] : (s3_wr[k] != 0 ? 32'h00077 : 0),
          s3_wr[k] != 0, s3_lb[k] >= 0, s3_lb[k], 20 + s3_lb[k]);
      if (k == gnt_k) host_req = 1'b0;
      step();
    end

    // Second line start during DRAIN: underrun, then queued fetch of y=2
    line_start = 1'b1; y_index = 9'd1; y_index_valid = 1'b1;
    step();
    line_start = 1'b0; y_index_valid = 1'b0; exp_bank = ~exp_bank;
    step();
    for (int k = 0; k < 14; k++) begin
      bit rd;
      bit lbw;
      int addr;
      int idx;
      #1;
      rd   = (k <= 3) || (k >= 7 && k <= 10);
      addr = (k <= 3) ? 4 + k : ((k >= 7 && k <= 10) ? k + 1 : 0);
      lbw  = (k >= 2 && k <= 5) || (k >= 9 && k <= 12);
      idx  = (k <= 5) ? k - 2 : k - 9;
      cyc($sformatf("s4_c%0d", k), rd, addr, 0, lbw, idx, (k <= 5) ? 4 + idx : 8 + idx);
      chk($sformatf("s4_underrun%0d", k), 32'(underrun), (k == 5) ? 1 : 0);
      chk($sformatf("s4_ucount%0d", k), 32'(underrun_count), (k >= 5) ? 1 : 0);
      chk($sformatf("s4_bank%0d", k), 32'(lb_bank), 32'(exp_bank));
      if (k == 4) begin
        line_start = 1'b1; y_index = 9'd2; y_index_valid = 1'b1;
      end
      step();
      if (k == 4) begin
        line_start = 1'b0; y_index_valid = 1'b0; exp_bank = ~exp_bank;
      end
    end

    // Reset during FETCH of y=6
    line_start = 1'b1; y_index = 9'd6; y_index_valid = 1'b1;
    step();
    line_start = 1'b0; y_index_valid = 1'b0; exp_bank = ~exp_bank;
    step();
    for (int k = 0; k < 3; k++) begin
      #1;
      cyc($sformatf("s6_c%0d", k), 1, 24 + k, 0, k == 2, 0, 24);
      if (k < 2) step();
    end
    reset = 1'b1;
    exp_bank = 1'b0;
    #1;
    cyc("s6_rst", 0, 0, 0, 0, 0, 0);
    chk("s6_rst_bank", 32'(lb_bank), 0);
    chk("s6_rst_underrun", 32'(underrun), 0);
    chk("s6_rst_ucount", 32'(underrun_count), 0);
    step();
    reset = 1'b0;
    // Stale read data is still returning here and must not be written
    #1;
    chk("s6_stale_rvalid_present", 32'(mem_rvalid), 1);
    cyc("s6_rel0", 0, 0, 0, 0, 0, 0);
    step();
    #1;
    cyc("s6_rel1", 0, 0, 0, 0, 0, 0);

    // Fresh fetch after reset starts cleanly at line-buffer index 0
    line_start = 1'b1; y_index = 9'd7; y_index_valid = 1'b1;
    step();
    line_start = 1'b0; y_index_valid = 1'b0; exp_bank = ~exp_bank;
    step();
    for (int k = 0; k < 7; k++) begin
      #1;
      cyc($sformatf("s7_c%0d", k), k < 4, (k < 4) ? 28 + k : 0, 0, (k >= 2 && k <= 5),
          k - 2, 26 + k);
      step();
    end

    // Invisible line: only the bank toggles
    line_start = 1'b1; y_index = 9'd9; y_index_valid = 1'b0;
    step();
    line_start = 1'b0; exp_bank = ~exp_bank;
    #1;
    chk("s8_bank", 32'(lb_bank), 32'(exp_bank));
    step();
    #1;
    cyc("s8_c0", 0, 0, 0, 0, 0, 0);
    step();
    #1;
    cyc("s8_c1", 0, 0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
